// File: rtl/prbs_pkg.sv
// Shared types and defaults for the PRBS bit-error-rate controller.
package prbs_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int RLK_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOCK,
      MEAS,
      DRAIN,
      DONE
   } state_e;

endpackage

// File: rtl/prbs_sat_cnt.sv
// Up counter with synchronous clear and saturation at all-ones.
module prbs_sat_cnt #(
   parameter int W = 16
) (
   input  logic         ck,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/prbs_ber_ctrl.sv
// PRBS BER test controller: lock, measure a window, drain, report.
// Define PRBS_BER_CTRL_RELOCK_EN to re-enter LOCK when lock drops in MEAS.
module prbs_ber_ctrl
   import prbs_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int RLK_W = RLK_W_DEF
) (
   input  logic             ck,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic             i_din_vld,
   input  logic [CNT_W-1:0] i_win_len,
   input  logic [CNT_W-1:0] i_lock_to,
   input  logic [CNT_W-1:0] i_err_thr,
   input  logic             i_lck,
   input  logic             i_err,
   input  logic             i_vld,
   output logic             o_req,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic             o_timeout,
   output logic [CNT_W-1:0] o_bit_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [RLK_W-1:0] o_rlk_cnt
);

   state_e           state;
   logic [CNT_W-1:0] win;
   logic [CNT_W-1:0] lock_to;
   logic [CNT_W-1:0] thr;
   logic [CNT_W-1:0] to_cnt;

   logic in_lock;
   logic in_meas;
   logic in_drain;
   logic go;
   logic lost_lock;
   logic bit_end;
   logic to_end;
   logic meas_clr;
   logic bit_en;
   logic err_en;
   logic to_clr;
   logic to_en;

   assign in_lock  = (state == LOCK);
   assign in_meas  = (state == MEAS);
   assign in_drain = (state == DRAIN);
   assign o_req    = i_din_vld & (in_lock | in_meas);
   assign o_busy   = (state != IDLE);
   assign go       = (state == IDLE) & i_start & ~i_abort;

`ifdef PRBS_BER_CTRL_RELOCK_EN
   assign lost_lock = in_meas & ~i_lck;
`else
   assign lost_lock = 1'b0;
`endif

   // End a phase on the request that reaches the limit, so no extra
   // request is issued past the window or timeout.
   assign bit_end = (o_bit_cnt == win)
                  | (o_req & ((o_bit_cnt + CNT_W'(1)) == win));
   assign to_end  = (to_cnt == lock_to)
                  | (o_req & ((to_cnt + CNT_W'(1)) == lock_to));

   assign meas_clr = go | ((in_lock & i_lck) & ~i_abort)
                   | (lost_lock & ~i_abort);
   assign bit_en   = in_meas & o_req & (o_bit_cnt != win) & ~i_abort;
   assign err_en   = (in_meas | in_drain) & i_vld & i_err & ~i_abort;
   assign to_clr   = go | (lost_lock & ~i_abort);
   assign to_en    = in_lock & o_req & (to_cnt != lock_to) & ~i_abort;

   prbs_sat_cnt #(.W(CNT_W)) u_bit_cnt (
      .ck    (ck),
      .rst_n (rst_n),
      .clr   (meas_clr),
      .en    (bit_en),
      .q     (o_bit_cnt)
   );

   prbs_sat_cnt #(.W(CNT_W)) u_err_cnt (
      .ck    (ck),
      .rst_n (rst_n),
      .clr   (meas_clr),
      .en    (err_en),
      .q     (o_err_cnt)
   );

   prbs_sat_cnt #(.W(CNT_W)) u_to_cnt (
      .ck    (ck),
      .rst_n (rst_n),
      .clr   (to_clr),
      .en    (to_en),
      .q     (to_cnt)
   );

`ifdef PRBS_BER_CTRL_RELOCK_EN
   prbs_sat_cnt #(.W(RLK_W)) u_rlk_cnt (
      .ck    (ck),
      .rst_n (rst_n),
      .clr   (go),
      .en    (lost_lock & ~i_abort),
      .q     (o_rlk_cnt)
   );
`else
   assign o_rlk_cnt = '0;
`endif

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         win       <= '0;
         lock_to   <= '0;
         thr       <= '0;
         o_done    <= 1'b0;
         o_pass    <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (i_abort) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (i_start) begin
                     state     <= LOCK;
                     win       <= i_win_len;
                     lock_to   <= i_lock_to;
                     thr       <= i_err_thr;
                     o_pass    <= 1'b0;
                     o_timeout <= 1'b0;
                  end
               end
               LOCK: begin
                  if (i_lck) begin
                     state <= MEAS;
                  end else if (to_end) begin
                     state     <= DONE;
                     o_timeout <= 1'b1;
                     o_pass    <= 1'b0;
                  end
               end
               MEAS: begin
                  if (lost_lock) begin
                     state <= LOCK;
                  end else if (bit_end) begin
                     state <= DRAIN;
                  end
               end
               DRAIN: begin
                  state <= DONE;
               end
               DONE: begin
                  o_pass <= ~o_timeout & (o_err_cnt <= thr);
                  o_done <= 1'b1;
                  state  <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prbs_ber_ctrl.sv
// Directed bench for prbs_ber_ctrl; honours PRBS_BER_CTRL_RELOCK_EN.
module tb_prbs_ber_ctrl;

   logic        ck;
   logic        rst_n;
   logic        i_start;
   logic        i_abort;
   logic        i_din_vld;
   logic [15:0] i_win_len;
   logic [15:0] i_lock_to;
   logic [15:0] i_err_thr;
   logic        i_lck;
   logic        i_err;
   logic        i_vld;
   logic        o_req;
   logic        o_busy;
   logic        o_done;
   logic        o_pass;
   logic        o_timeout;
   logic [15:0] o_bit_cnt;
   logic [15:0] o_err_cnt;
   logic [7:0]  o_rlk_cnt;

   logic err_pat;
   int   n_chk;
   int   n_fail;

   prbs_ber_ctrl dut (
      .ck        (ck),
      .rst_n     (rst_n),
      .i_start   (i_start),
      .i_abort   (i_abort),
      .i_din_vld (i_din_vld),
      .i_win_len (i_win_len),
      .i_lock_to (i_lock_to),
      .i_err_thr (i_err_thr),
      .i_lck     (i_lck),
      .i_err     (i_err),
      .i_vld     (i_vld),
      .o_req     (o_req),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_pass    (o_pass),
      .o_timeout (o_timeout),
      .o_bit_cnt (o_bit_cnt),
      .o_err_cnt (o_err_cnt),
      .o_rlk_cnt (o_rlk_cnt)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   // Checker model: result one cycle after each request.
   always @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         i_vld <= 1'b0;
         i_err <= 1'b0;
      end else begin
         i_vld <= o_req;
         i_err <= o_req & err_pat;
      end
   end

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic start_test(input logic [15:0] w, input logic [15:0] t,
                             input logic [15:0] th);
      i_win_len = w;
      i_lock_to = t;
      i_err_thr = th;
      i_start   = 1'b1;
      tick();
      i_start   = 1'b0;
   endtask

   task automatic wait_done(output int nd);
      nd = 0;
      repeat (6) begin
         tick();
         if (o_done) nd++;
      end
   endtask

   task automatic test_reset();
      i_din_vld = 1'b1;
      #1;
      n_chk++;
      if (o_busy !== 1'b0 || o_req !== 1'b0 || o_done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ctl: busy/req/done=%b%b%b want 000",
                  o_busy, o_req, o_done);
      end
      n_chk++;
      if (o_pass !== 1'b0 || o_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_res: pass/to=%b%b want 00", o_pass, o_timeout);
      end
      n_chk++;
      if (o_bit_cnt !== 16'd0 || o_err_cnt !== 16'd0 || o_rlk_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_cnt: bit=%0d err=%0d rlk=%0d want 0",
                  o_bit_cnt, o_err_cnt, o_rlk_cnt);
      end
      rst_n = 1'b1;
      tick();
      tick();
      n_chk++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_idle: busy=%b want 0", o_busy);
      end
   endtask

   task automatic test_clean_window();
      int nd;
      i_din_vld = 1'b1;
      i_lck     = 1'b0;
      err_pat   = 1'b0;
      start_test(16'd100, 16'd1000, 16'd0);
      n_chk++;
      if (o_busy !== 1'b1 || o_req !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_entry: busy/req=%b%b want 11", o_busy, o_req);
      end
      repeat (4) tick();
      i_lck = 1'b1;
      tick();
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (k == 50) begin
            n_chk++;
            if (o_bit_cnt !== 16'd50) begin
               n_fail++;
               $display("FAIL clean_mid: bit=%0d want 50", o_bit_cnt);
            end
         end
      end
      wait_done(nd);
      n_chk++;
      if (nd !== 1) begin
         n_fail++;
         $display("FAIL clean_done: pulses=%0d want 1", nd);
      end
      n_chk++;
      if (o_bit_cnt !== 16'd100 || o_err_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL clean_cnt: bit=%0d err=%0d want 100 0",
                  o_bit_cnt, o_err_cnt);
      end
      n_chk++;
      if (o_pass !== 1'b1 || o_timeout !== 1'b0 || o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL clean_res: pass/to/busy=%b%b%b want 100",
                  o_pass, o_timeout, o_busy);
      end
   endtask

   task automatic test_err_last();
      int nd;
      i_lck = 1'b1;
      start_test(16'd64, 16'd1000, 16'd2);
      tick();
      for (int k = 1; k <= 64; k++) begin
         err_pat = (k == 7) || (k == 40) || (k == 64);
         tick();
      end
      err_pat = 1'b0;
      n_chk++;
      if (o_err_cnt !== 16'd2 || o_bit_cnt !== 16'd64) begin
         n_fail++;
         $display("FAIL err_predrain: err=%0d bit=%0d want 2 64",
                  o_err_cnt, o_bit_cnt);
      end
      wait_done(nd);
      n_chk++;
      if (o_err_cnt !== 16'd3 || nd !== 1) begin
         n_fail++;
         $display("FAIL err_final: err=%0d done=%0d want 3 1", o_err_cnt, nd);
      end
      n_chk++;
      if (o_pass !== 1'b0) begin
         n_fail++;
         $display("FAIL err_pass: pass=%b want 0", o_pass);
      end
   endtask

   task automatic test_thr_equal();
      int nd;
      i_lck = 1'b1;
      start_test(16'd16, 16'd1000, 16'd1);
      tick();
      for (int k = 1; k <= 16; k++) begin
         err_pat = (k == 5);
         tick();
      end
      err_pat = 1'b0;
      wait_done(nd);
      n_chk++;
      if (o_err_cnt !== 16'd1 || o_pass !== 1'b1 || nd !== 1) begin
         n_fail++;
         $display("FAIL thr_eq: err=%0d pass=%b done=%0d want 1 1 1",
                  o_err_cnt, o_pass, nd);
      end
   endtask

   task automatic test_timeout();
      i_lck = 1'b0;
      start_test(16'd100, 16'd10, 16'd0);
      repeat (9) tick();
      n_chk++;
      if (o_busy !== 1'b1 || o_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL to_early: busy/to=%b%b want 10", o_busy, o_timeout);
      end
      tick();
      n_chk++;
      if (o_timeout !== 1'b1 || o_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL to_hit: to/busy=%b%b want 11", o_timeout, o_busy);
      end
      tick();
      n_chk++;
      if (o_done !== 1'b1 || o_pass !== 1'b0 || o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL to_done: done/pass/busy=%b%b%b want 100",
                  o_done, o_pass, o_busy);
      end
   endtask

   task automatic test_abort();
      int nd;
      i_lck = 1'b1;
      start_test(16'd100, 16'd1000, 16'd0);
      tick();
      repeat (20) tick();
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      n_chk++;
      if (o_busy !== 1'b0 || o_bit_cnt !== 16'd20 || o_done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort: busy=%b bit=%0d done=%b want 0 20 0",
                  o_busy, o_bit_cnt, o_done);
      end
      wait_done(nd);
      n_chk++;
      if (nd !== 0 || o_bit_cnt !== 16'd20) begin
         n_fail++;
         $display("FAIL abort_hold: done=%0d bit=%0d want 0 20", nd, o_bit_cnt);
      end
      i_start = 1'b1;
      i_abort = 1'b1;
      tick();
      i_start = 1'b0;
      i_abort = 1'b0;
      n_chk++;
      if (o_busy !== 1'b0 || o_bit_cnt !== 16'd20) begin
         n_fail++;
         $display("FAIL abort_start: busy=%b bit=%0d want 0 20",
                  o_busy, o_bit_cnt);
      end
   endtask

   task automatic test_relock();
      int nd;
      logic [7:0] rlk_exp;
      i_lck = 1'b1;
      start_test(16'd50, 16'd1000, 16'd0);
      tick();
      repeat (30) tick();
      i_lck = 1'b0;
      tick();
`ifdef PRBS_BER_CTRL_RELOCK_EN
      rlk_exp = 8'd1;
      n_chk++;
      if (o_bit_cnt !== 16'd0 || o_rlk_cnt !== 8'd1 || o_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL relock: bit=%0d rlk=%0d busy=%b want 0 1 1",
                  o_bit_cnt, o_rlk_cnt, o_busy);
      end
      i_lck = 1'b1;
      tick();
      repeat (50) tick();
`else
      rlk_exp = 8'd0;
      n_chk++;
      if (o_bit_cnt !== 16'd31 || o_rlk_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL no_relock: bit=%0d rlk=%0d want 31 0",
                  o_bit_cnt, o_rlk_cnt);
      end
      i_lck = 1'b1;
      repeat (19) tick();
`endif
      wait_done(nd);
      n_chk++;
      if (o_bit_cnt !== 16'd50 || o_rlk_cnt !== rlk_exp || nd !== 1) begin
         n_fail++;
         $display("FAIL relock_end: bit=%0d rlk=%0d done=%0d want 50 %0d 1",
                  o_bit_cnt, o_rlk_cnt, nd, rlk_exp);
      end
   endtask

   task automatic test_win_zero();
      int nd;
      i_lck = 1'b1;
      start_test(16'd0, 16'd1000, 16'd0);
      tick();
      tick();
      n_chk++;
      if (o_bit_cnt !== 16'd0 || o_busy !== 1'b1 || o_req !== 1'b0) begin
         n_fail++;
         $display("FAIL win0_drain: bit=%0d busy=%b req=%b want 0 1 0",
                  o_bit_cnt, o_busy, o_req);
      end
      wait_done(nd);
      n_chk++;
      if (nd !== 1 || o_bit_cnt !== 16'd0 || o_pass !== 1'b1) begin
         n_fail++;
         $display("FAIL win0_end: done=%0d bit=%0d pass=%b want 1 0 1",
                  nd, o_bit_cnt, o_pass);
      end
   endtask

   task automatic test_reset_mid();
      int nd;
      i_lck = 1'b1;
      start_test(16'd40, 16'd1000, 16'd0);
      tick();
      repeat (10) tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (o_busy !== 1'b0 || o_req !== 1'b0 || o_bit_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL arst: busy=%b req=%b bit=%0d want 0 0 0",
                  o_busy, o_req, o_bit_cnt);
      end
      n_chk++;
      if (o_pass !== 1'b0 || o_done !== 1'b0 || o_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_st: pass/done/to=%b%b%b want 000",
                  o_pass, o_done, o_timeout);
      end
      #2;
      rst_n = 1'b1;
      tick();
      n_chk++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_resume: busy=%b want 0", o_busy);
      end
      start_test(16'd20, 16'd1000, 16'd0);
      tick();
      repeat (5) tick();
      i_start   = 1'b1;
      i_win_len = 16'd3;
      tick();
      i_start   = 1'b0;
      n_chk++;
      if (o_bit_cnt !== 16'd6 || o_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_start: bit=%0d busy=%b want 6 1",
                  o_bit_cnt, o_busy);
      end
      repeat (14) tick();
      wait_done(nd);
      n_chk++;
      if (o_bit_cnt !== 16'd20 || nd !== 1) begin
         n_fail++;
         $display("FAIL busy_end: bit=%0d done=%0d want 20 1", o_bit_cnt, nd);
      end
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      err_pat   = 1'b0;
      rst_n     = 1'b0;
      i_start   = 1'b0;
      i_abort   = 1'b0;
      i_din_vld = 1'b0;
      i_win_len = '0;
      i_lock_to = '0;
      i_err_thr = '0;
      i_lck     = 1'b0;
      repeat (2) @(posedge ck);
      #1;
      test_reset();
      test_clean_window();
      test_err_last();
      test_thr_equal();
      test_timeout();
      test_abort();
      test_relock();
      test_win_zero();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/prbs_ber_ctrl.md
PRBS_BER_CTRL -- requirements
Module: prbs_ber_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the window, timeout, threshold and count fields.
REQ-002 Parameter RLK_W, default 8, SHALL set the relock counter width.
REQ-003 ck  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_start  in  1  one-cycle pulse that starts a test; ignored unless the FSM is in IDLE.
REQ-006 i_abort  in  1  forces IDLE from any state.
REQ-007 i_din_vld  in  1  receive bit available this cycle.
REQ-008 i_win_len, i_lock_to, i_err_thr  in  CNT_W each  measurement window in bits, lock timeout in request cycles, and pass threshold.
REQ-009 i_lck, i_err, i_vld  in  1 each  lock, error and valid outputs of the PRBS checker; i_err and i_vld lag o_req by one cycle.
REQ-010 o_req  out  1  bit request to the checker.
REQ-011 o_busy, o_done, o_pass, o_timeout  out  1 each  status; o_done is a one-cycle pulse.
REQ-012 o_bit_cnt, o_err_cnt  out  CNT_W each  measured bits and errors.
REQ-013 o_rlk_cnt  out  RLK_W  relock count (macro-dependent).

Function
REQ-014 The FSM SHALL use the states IDLE, LOCK, MEAS, DRAIN and DONE.
REQ-015 o_req SHALL equal i_din_vld AND (state is LOCK or MEAS), combinationally.
REQ-016 IDLE with i_start SHALL move to LOCK, latch i_win_len, i_lock_to and i_err_thr, and clear all counts, o_pass and o_timeout.
REQ-017 LOCK SHALL increment the timeout counter on each o_req cycle.
REQ-018 LOCK with i_lck=1 SHALL move to MEAS and clear the bit and error counts; lock takes priority over timeout in the same cycle.
REQ-019 LOCK with timeout count equal to the latched i_lock_to SHALL move to DONE with o_timeout=1 and o_pass=0.
REQ-020 MEAS SHALL increment o_bit_cnt on each o_req cycle.
REQ-021 In MEAS and DRAIN, i_vld&i_err SHALL increment o_err_cnt, saturating at all-ones.
REQ-022 MEAS SHALL move to DRAIN when o_bit_cnt equals the latched window; a window of 0 moves to DRAIN on the first MEAS cycle with zero bits counted.
REQ-023 DRAIN SHALL last exactly one cycle with o_req=0, so the final in-flight result is counted, then move to DONE.
REQ-024 DONE SHALL set o_pass=(o_err_cnt <= threshold) unless a timeout occurred, pulse o_done for one cycle, and return to IDLE.
REQ-025 Results SHALL hold until the next accepted i_start.
REQ-026 o_busy SHALL be 1 in every state except IDLE.
REQ-027 i_abort SHALL go to IDLE next cycle with no o_done, hold the counts, and take priority over every other transition, including a same-cycle i_start.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, all counts to 0, and o_done, o_pass, o_timeout, o_busy and o_req to 0.
REQ-029 Deassertion of rst_n mid-test SHALL resume from IDLE only; no state is retained.

Configuration
REQ-030 With PRBS_BER_CTRL_RELOCK_EN defined, i_lck=0 in MEAS SHALL return the FSM to LOCK, clear the bit, error and timeout counts, and increment o_rlk_cnt, saturating.
REQ-031 With PRBS_BER_CTRL_RELOCK_EN undefined, MEAS SHALL ignore i_lck and o_rlk_cnt SHALL be tied to 0.

Structure
REQ-032 Package prbs_pkg SHALL hold the FSM state enum and the default CNT_W and RLK_W constants.
REQ-033 Sub-module prbs_sat_cnt SHALL implement a clear/enable saturating counter and be instanced for the bit, error, timeout and relock counts.

Verification
REQ-034 Window 100, threshold 0, i_din_vld=1, lock after 5 cycles, no errors -> o_bit_cnt=100, o_err_cnt=0, o_pass=1, one o_done pulse.
REQ-035 Window 64, threshold 2, 3 errors injected, the last on the final bit -> o_err_cnt=3 (DRAIN captures it), o_pass=0.
REQ-036 i_lock_to=10, i_lck held 0 -> DONE after 10 request cycles with o_timeout=1, o_pass=0.
REQ-037 i_abort in MEAS at bit 20 -> IDLE next cycle, no o_done, o_bit_cnt=20 held.
REQ-038 With the macro, lock dropped at bit 30 then regained -> o_rlk_cnt=1 and a full window is counted afterwards; without the macro -> no relock and the window completes.
REQ-039 rst_n pulsed low mid-MEAS -> all outputs 0 immediately (asynchronous); i_start issued while busy is ignored.
